// File: rtl/mul_stream_core.sv
// Signed 32x32 iterative shift-add multiplier that streams its 64-bit product out LSB byte first.
// One job per rising edge of start_calc; core_busy holds off the loader until the last byte is taken.
module mul_stream_core #(
  parameter int DATA_W = 32,
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] a1,
  input  logic              start_calc,
  output logic              core_busy,
  output logic [BYTE_W-1:0] out_byte,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic [1:0]        dbg_state
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int NBYTES = PROD_W / BYTE_W;
  localparam int CNT_W  = $clog2(DATA_W);
  localparam int BEAT_W = $clog2(NBYTES);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DATA_W - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(NBYTES - 1);

  // Output handshake: a beat transfers on a rising clk edge where
  // ena & out_valid & out_ready; while not transferred, out_byte/out_last hold.
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_FIX, S_OUT} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_start_d;
  logic                r_busy;
  logic                r_neg;
  logic [DATA_W-1:0]   r_mcand;
  logic [DATA_W-1:0]   r_mplier;
  logic [PROD_W-1:0]   r_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic [BEAT_W-1:0]   r_beat;

  logic                w_start_edge;
  logic                w_accept;
  logic                w_beat_last;
  logic [DATA_W-1:0]   w_abs_a0;
  logic [DATA_W-1:0]   w_abs_a1;
  logic [PROD_W-1:0]   w_addend;

  assign w_start_edge = start_calc & ~r_start_d;
  assign w_accept     = ena & (r_state == S_OUT) & out_ready;
  assign w_beat_last  = (r_beat == BEAT_LAST);
  // Negating the most negative value wraps to itself, which is the correct unsigned magnitude.
  assign w_abs_a0     = a0[DATA_W-1] ? (-a0) : a0;
  assign w_abs_a1     = a1[DATA_W-1] ? (-a1) : a1;
  assign w_addend     = {{DATA_W{1'b0}}, r_mcand} << r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else if (ena) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_edge) w_state_nxt = S_MUL;
      S_MUL:   if (r_cnt == CNT_LAST) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_OUT;
      S_OUT:   if (out_ready && w_beat_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_d <= 1'b0;
      r_busy    <= 1'b0;
      r_neg     <= 1'b0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_beat    <= '0;
    end else if (ena) begin
      r_start_d <= start_calc;
      case (r_state)
        S_IDLE: begin
          if (w_start_edge) begin
            r_mcand  <= w_abs_a0;
            r_mplier <= w_abs_a1;
            r_neg    <= a0[DATA_W-1] ^ a1[DATA_W-1];
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
          end
        end
        S_MUL: begin
          if (r_mplier[0]) r_acc <= r_acc + w_addend;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CNT_W'(1);
        end
        S_FIX: begin
          if (r_neg) r_acc <= -r_acc;
          r_beat <= '0;
        end
        S_OUT: begin
          if (out_ready) begin
            r_beat <= r_beat + BEAT_W'(1);
            if (w_beat_last) r_busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign core_busy = r_busy;
  assign out_valid = (r_state == S_OUT);
  assign out_last  = out_valid & w_beat_last;
  assign out_byte  = out_valid ? r_acc[int'(r_beat)*BYTE_W +: BYTE_W] : '0;
  assign dbg_state = r_state;

  // w_accept documents the transfer condition; the OUT branch above applies it under ena.
  logic w_unused;
  assign w_unused = w_accept;

endmodule

// File: tb/tb_mul_stream_core.sv
// Directed bench for mul_stream_core: stimulus pushes expected {last,byte} beats,
// an independent monitor pops and compares every accepted beat and checks stall stability.
module tb_mul_stream_core;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic [31:0] a0;
  logic [31:0] a1;
  logic        start_calc;
  logic        core_busy;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;
  logic [1:0]  dbg_state;

  logic [8:0]  exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  bit          rand_mode = 0;
  int          cyc = 0;

  mul_stream_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .a0         (a0),
    .a1         (a1),
    .start_calc (start_calc),
    .core_busy  (core_busy),
    .out_byte   (out_byte),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // random ready / ena every-third-cycle driver
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (rand_mode) begin
      out_ready = 1'($urandom_range(0, 1));
      ena       = (cyc % 3 != 2);
    end
  end

  // monitor / scoreboard
  logic [8:0] held;
  bit         stalled = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 0;
    end else begin
      if (stalled)
        chk("stall_hold", {out_valid, out_last, out_byte}, {1'b1, held});
      if (out_valid && ena && out_ready) begin
        stalled = 0;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {out_last, out_byte}, 9'h1FF);
        end else begin
          chk("beat", {out_last, out_byte}, exp_q.pop_front());
        end
      end else if (out_valid) begin
        stalled = 1;
        held    = {out_last, out_byte};
      end else begin
        stalled = 0;
      end
    end
  end

  // driver tasks
  task automatic push_exp(input logic [63:0] p);
    for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), p[i*8 +: 8]});
  endtask

  task automatic start_job(input logic [31:0] x, input logic [31:0] y, input bit hold);
    int n;
    a0 = x;
    a1 = y;
    start_calc = 1'b1;
    n = 0;
    while (!core_busy && n < 200) begin
      step();
      n++;
    end
    chk("start_accept", {63'd0, core_busy}, 64'd1);
    if (!hold) start_calc = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (core_busy && n < 3000) begin
      step();
      n++;
    end
    chk(nm, {63'd0, core_busy}, 64'd0);
    repeat (3) step();
    chk({nm, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic quiet(input int cycles, input string nm);
    int busy_n;
    busy_n = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (core_busy || out_valid) busy_n++;
    end
    chk(nm, 64'(busy_n), 64'd0);
  endtask

  task automatic check_zero_outputs(input string nm);
    chk(nm, {52'd0, core_busy, out_valid, out_last, out_byte, dbg_state}, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    ena = 1'b1;
    out_ready = 1'b1;
    start_calc = 1'b0;
    a0 = '0;
    a1 = '0;
    repeat (3) step();
    check_zero_outputs("reset_state");
    rst_n = 1'b1;
    step();
    check_zero_outputs("idle_after_reset");

    // 1) 3*5 with latency check
    push_exp(64'd15);
    a0 = 32'd3;
    a1 = 32'd5;
    start_calc = 1'b1;
    step();
    chk("busy_rise", {63'd0, core_busy}, 64'd1);
    start_calc = 1'b0;
    repeat (32) step();
    chk("no_early_valid", {63'd0, out_valid}, 64'd0);
    step();
    chk("first_valid_n34", {63'd0, out_valid}, 64'd1);
    wait_idle("case1_done");

    // 2) signed products and corner ranges
    push_exp(64'hFFFF_FFFF_FFFF_FFC1);
    start_job(-32'sd7, 32'sd9, 0);
    wait_idle("neg63_done");
    push_exp(64'h4000_0000_0000_0000);
    start_job(32'h8000_0000, 32'h8000_0000, 0);
    wait_idle("min_sq_done");
    push_exp(64'd0);
    start_job(32'd0, 32'hFFFF_FFFF, 0);
    wait_idle("zero_neg_done");
    push_exp(64'hC000_0000_8000_0000);
    start_job(32'h7FFF_FFFF, 32'h8000_0000, 0);
    wait_idle("max_min_done");

    // 4) held start never retriggers; edge during MUL ignored
    push_exp(64'd15);
    start_job(32'd3, 32'd5, 1);
    wait_idle("hold_job_done");
    quiet(100, "hold_no_retrigger");
    start_calc = 1'b0;
    step();
    push_exp(64'd6);
    start_job(32'd2, 32'd3, 0);
    repeat (5) step();
    start_calc = 1'b1;
    step();
    start_calc = 1'b0;
    wait_idle("mul_edge_job_done");
    quiet(60, "mul_edge_ignored");

    // 5) random ready, ena toggling: same bytes as case 1
    rand_mode = 1;
    push_exp(64'd15);
    start_job(32'd3, 32'd5, 0);
    wait_idle("rand_job_done");
    push_exp(64'hFFFF_FFFF_FFFF_FFC1);
    start_job(-32'sd7, 32'sd9, 0);
    wait_idle("rand_neg_done");
    rand_mode = 0;
    step();
    ena = 1'b1;
    out_ready = 1'b1;
    step();

    // 6) reset during MUL, then during OUT (stalled)
    start_job(32'd3, 32'd5, 0);
    repeat (10) step();
    rst_n = 1'b0;
    step();
    check_zero_outputs("reset_in_mul");
    rst_n = 1'b1;
    quiet(50, "no_beat_after_mul_reset");
    out_ready = 1'b0;
    start_job(32'd3, 32'd5, 0);
    repeat (40) step();
    chk("stalled_in_out", {63'd0, out_valid}, 64'd1);
    rst_n = 1'b0;
    step();
    check_zero_outputs("reset_in_out");
    rst_n = 1'b1;
    out_ready = 1'b1;
    quiet(50, "no_beat_after_out_reset");
    push_exp(64'hFFFF_FFFF_FFFF_FFC1);
    start_job(-32'sd7, 32'sd9, 0);
    wait_idle("post_reset_job_done");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
